// File: rtl/memory_req_arbiter.sv
// memory_req_arbiter
//   Front-end scheduler for the home-node memory block. Four requesters
//   (D-cache request, D-cache reply, I-cache reply, IN-fifos) share the
//   memory block's single input port. One requester is picked round-robin,
//   its payload is latched, and exactly one memory-side valid is driven
//   until mem_access_done. The winner is then acked for one cycle and the
//   arbiter returns to IDLE through that ACK bubble.
//
//   Optional feature (macro MEM_ARB_WATCHDOG_EN): a BUSY watchdog. If no
//   mem_access_done arrives within TIMEOUT_CYCLES BUSY cycles, the access
//   is abandoned, the winner is acked and timeout_err pulses with the ack.
//   Without the macro there is no counter, timeout_err is tied low and BUSY
//   waits indefinitely.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   v_d_req/v_d_rep/v_i_rep/v_INfifos  request valids, held until acked
//   d_head_in/d_addr_in/d_data_in D-cache payload (shared by d_req, d_rep)
//   i_addr_in                     I-cache address
//   infifos_*_in                  IN-fifo payload
//   mem_access_done               memory block finished the current access
//   v_*_o                         one-hot valids to the memory block
//   head_o/addr_o/data_o          latched payload to the memory block
//   ack_*                         one-cycle completion pulses
//   grant_id                      winner: 0=d_req 1=d_rep 2=i_rep 3=infifos
//   busy                          high in BUSY and ACK
//   timeout_err                   one-cycle watchdog pulse
module memory_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_d_req,
  input  logic         v_d_rep,
  input  logic         v_i_rep,
  input  logic         v_INfifos,
  input  logic [15:0]  d_head_in,
  input  logic [31:0]  d_addr_in,
  input  logic [127:0] d_data_in,
  input  logic [31:0]  i_addr_in,
  input  logic [15:0]  infifos_head_in,
  input  logic [31:0]  infifos_addr_in,
  input  logic [127:0] infifos_data_in,
  input  logic         mem_access_done,
  output logic         v_d_req_o,
  output logic         v_d_rep_o,
  output logic         v_i_rep_o,
  output logic         v_INfifos_o,
  output logic [15:0]  head_o,
  output logic [31:0]  addr_o,
  output logic [127:0] data_o,
  output logic         ack_d_req,
  output logic         ack_d_rep,
  output logic         ack_i_rep,
  output logic         ack_infifos,
  output logic [1:0]   grant_id,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [3:0] vld_q;
  logic [3:0] ack_q;
  logic [3:0] req_vec;
  logic [1:0] pick;

`ifdef MEM_ARB_WATCHDOG_EN
  // The last BUSY cycle on which done is still accepted; the counter is 0
  // on the first BUSY cycle, so it equals TIMEOUT_CYCLES-1 on the limit cycle.
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Bit order matches grant_id encoding.
  assign req_vec = {v_INfifos, v_i_rep, v_d_rep, v_d_req};
  assign {v_INfifos_o, v_i_rep_o, v_d_rep_o, v_d_req_o} = vld_q;
  assign {ack_infifos, ack_i_rep, ack_d_rep, ack_d_req} = ack_q;

  // First asserted request searching ptr, ptr+1, ... (mod 4). Scanning the
  // offsets from farthest to nearest lets the nearest hit overwrite the rest.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign pick = rr_pick(req_vec, rr_ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      vld_q    <= '0;
      ack_q    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      head_o   <= '0;
      addr_o   <= '0;
      data_o   <= '0;
`ifdef MEM_ARB_WATCHDOG_EN
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // Acks and the watchdog flag are single-cycle pulses.
      ack_q <= '0;
`ifdef MEM_ARB_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req_vec) begin
            grant_id <= pick;
            vld_q    <= 4'b0001 << pick;
            busy     <= 1'b1;
            state    <= BUSY;
            // Payload is captured only here and held through BUSY.
            case (pick)
              2'd0, 2'd1: begin
                head_o <= d_head_in;
                addr_o <= d_addr_in;
                data_o <= d_data_in;
              end
              2'd2: begin
                head_o <= '0;
                addr_o <= i_addr_in;
                data_o <= '0;
              end
              default: begin
                head_o <= infifos_head_in;
                addr_o <= infifos_addr_in;
                data_o <= infifos_data_in;
              end
            endcase
`ifdef MEM_ARB_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
        end

        BUSY: begin
          // Request valids are not looked at here; only done (or the
          // watchdog) ends the access. Done on the limit cycle wins.
          if (mem_access_done) begin
            vld_q  <= '0;
            ack_q  <= 4'b0001 << grant_id;
            rr_ptr <= grant_id + 2'd1;
            state  <= ACK;
          end
`ifdef MEM_ARB_WATCHDOG_EN
          else if (wd_cnt == TIMEOUT_LIM) begin
            vld_q     <= '0;
            ack_q     <= 4'b0001 << grant_id;
            rr_ptr    <= grant_id + 2'd1;
            timeout_q <= 1'b1;
            state     <= ACK;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end

        ACK: begin
          // One-cycle bubble so the acked requester can drop its valid
          // before the next arbitration.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          vld_q <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_req_arbiter.sv
module tb_memory_req_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         v_d_req = 1'b0, v_d_rep = 1'b0, v_i_rep = 1'b0, v_INfifos = 1'b0;
  logic [15:0]  d_head_in = '0;
  logic [31:0]  d_addr_in = '0;
  logic [127:0] d_data_in = '0;
  logic [31:0]  i_addr_in = '0;
  logic [15:0]  infifos_head_in = '0;
  logic [31:0]  infifos_addr_in = '0;
  logic [127:0] infifos_data_in = '0;
  logic         mem_access_done = 1'b0;
  logic         v_d_req_o, v_d_rep_o, v_i_rep_o, v_INfifos_o;
  logic [15:0]  head_o;
  logic [31:0]  addr_o;
  logic [127:0] data_o;
  logic         ack_d_req, ack_d_rep, ack_i_rep, ack_infifos;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  memory_req_arbiter dut (
    .clk(clk), .rst(rst),
    .v_d_req(v_d_req), .v_d_rep(v_d_rep), .v_i_rep(v_i_rep), .v_INfifos(v_INfifos),
    .d_head_in(d_head_in), .d_addr_in(d_addr_in), .d_data_in(d_data_in),
    .i_addr_in(i_addr_in),
    .infifos_head_in(infifos_head_in), .infifos_addr_in(infifos_addr_in),
    .infifos_data_in(infifos_data_in),
    .mem_access_done(mem_access_done),
    .v_d_req_o(v_d_req_o), .v_d_rep_o(v_d_rep_o), .v_i_rep_o(v_i_rep_o),
    .v_INfifos_o(v_INfifos_o),
    .head_o(head_o), .addr_o(addr_o), .data_o(data_o),
    .ack_d_req(ack_d_req), .ack_d_rep(ack_d_rep), .ack_i_rep(ack_i_rep),
    .ack_infifos(ack_infifos),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [3:0] vld_vec, ack_vec;
  assign vld_vec = {v_INfifos_o, v_i_rep_o, v_d_rep_o, v_d_req_o};
  assign ack_vec = {ack_infifos, ack_i_rep, ack_d_rep, ack_d_req};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]   req;
    logic [15:0]  dh;
    logic [31:0]  da;
    logic [127:0] dd;
    logic [31:0]  ia;
    logic [15:0]  fh;
    logic [31:0]  fa;
    logic [127:0] fd;
    logic [1:0]   gid;
  } vec_t;

  typedef struct {
    logic [1:0]   gid;
    logic [15:0]  head;
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  vec_t       tbl [8];
  exp_t       exp_q [$];
  logic [1:0] gid_q [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_valids(input logic [3:0] v);
    {v_INfifos, v_i_rep, v_d_rep, v_d_req} = v;
  endtask

  // Expected memory-side payload for a given winner.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.gid = v.gid;
    case (v.gid)
      2'd0, 2'd1: begin e.head = v.dh; e.addr = v.da; e.data = v.dd; end
      2'd2:       begin e.head = '0;   e.addr = v.ia; e.data = '0;   end
      default:    begin e.head = v.fh; e.addr = v.fa; e.data = v.fd; end
    endcase
    return e;
  endfunction

  task automatic drive(input vec_t v);
    d_head_in       = v.dh;
    d_addr_in       = v.da;
    d_data_in       = v.dd;
    i_addr_in       = v.ia;
    infifos_head_in = v.fh;
    infifos_addr_in = v.fa;
    infifos_data_in = v.fd;
    set_valids(v.req);
  endtask

  // Waits on negedges for a memory-side valid, bounded to 10 cycles.
  task automatic wait_vld(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (vld_vec == 4'b0 && lat < 10);
  endtask

  // Called on the negedge where valid_o is visible: done for one cycle,
  // check the ack cycle and the IDLE bubble after it.
  task automatic finish_txn(input logic [1:0] g, input logic [31:0] a);
    mem_access_done = 1'b1;
    @(negedge clk);
    mem_access_done = 1'b0;
    chk("ack_onehot", 256'(ack_vec), 256'(4'b0001 << g));
    chk("vld_cleared", 256'(vld_vec), 256'(0));
    chk("busy_in_ack", 256'(busy), 256'(1));
    chk("addr_until_ack", 256'(addr_o), 256'(a));
    set_valids(4'b0000);
    @(negedge clk);
    chk("ack_single_cycle", 256'(ack_vec), 256'(0));
    chk("busy_idle", 256'(busy), 256'(0));
    chk("gid_hold", 256'(grant_id), 256'(g));
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   lat;
    @(negedge clk);
    drive(v);
    exp_q.push_back(model(v));
    wait_vld(lat);
    chk("grant_latency", 256'(lat), 256'(1));
    if (vld_vec != 4'b0) begin
      e = exp_q.pop_front();
      chk("grant_id", 256'(grant_id), 256'(e.gid));
      chk("vld_onehot", 256'(vld_vec), 256'(4'b0001 << e.gid));
      chk("head_o", 256'(head_o), 256'(e.head));
      chk("addr_o", 256'(addr_o), 256'(e.addr));
      chk("data_o", 256'(data_o), 256'(e.data));
      chk("busy_in_busy", 256'(busy), 256'(1));
      @(negedge clk);
      chk("vld_held", 256'(vld_vec), 256'(4'b0001 << e.gid));
      finish_txn(e.gid, e.addr);
    end else begin
      exp_q.delete();
      set_valids(4'b0000);
    end
  endtask

  // All four requesters held; done two cycles after each grant.
  task automatic all_four(input int n, input logic [1:0] first);
    int         w;
    logic [1:0] g;
    for (int k = 0; k < n; k++) gid_q.push_back(first + 2'(k));
    @(negedge clk);
    set_valids(4'b1111);
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
        chk("all4_at_most_one_vld", 256'($countones(vld_vec) <= 1), 256'(1));
      end while (vld_vec == 4'b0 && w < 10);
      if (vld_vec == 4'b0) begin
        chk("all4_grant_wait", 256'(0), 256'(1));
        gid_q.delete();
        break;
      end
      g = gid_q.pop_front();
      chk("all4_gid", 256'(grant_id), 256'(g));
      chk("all4_vld", 256'(vld_vec), 256'(4'b0001 << g));
      @(negedge clk);
      chk("all4_vld_hold", 256'(vld_vec), 256'(4'b0001 << g));
      @(negedge clk);
      mem_access_done = 1'b1;
      @(negedge clk);
      mem_access_done = 1'b0;
      chk("all4_ack", 256'(ack_vec), 256'(4'b0001 << g));
      chk("all4_vld_off", 256'(vld_vec), 256'(0));
      if (k == n - 1) set_valids(4'b0000);
      @(negedge clk);
      chk("all4_ack_off", 256'(ack_vec), 256'(0));
      chk("all4_bubble_vld", 256'(vld_vec), 256'(0));
    end
    set_valids(4'b0000);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    vec_t tv;
    int   lat;
    int   hi;
    int   te;

    for (int i = 0; i < 8; i++) begin
      tbl[i].dh = 16'hD000 | 16'(i);
      tbl[i].da = 32'h0000_1040 + 32'(i) * 32'h100;
      tbl[i].dd = {4{32'hDA7A_0000 | 32'(i)}};
      tbl[i].ia = 32'hABCD_0100 + 32'(i);
      tbl[i].fh = 16'hF000 | 16'(i);
      tbl[i].fa = 32'h8000_0000 + 32'(i);
      tbl[i].fd = {4{32'hF1F0_0000 | 32'(i)}};
    end
    // Expected winners follow the round-robin pointer left by the entry before.
    tbl[0].req = 4'b0001; tbl[0].gid = 2'd0;
    tbl[1].req = 4'b1111; tbl[1].gid = 2'd1;
    tbl[2].req = 4'b0101; tbl[2].gid = 2'd2;
    tbl[2].dd  = '1;      tbl[2].ia  = 32'hABCD_0000;
    tbl[3].req = 4'b0011; tbl[3].gid = 2'd0;
    tbl[4].req = 4'b1000; tbl[4].gid = 2'd3;
    tbl[5].req = 4'b1110; tbl[5].gid = 2'd1;
    tbl[6].req = 4'b1011; tbl[6].gid = 2'd3;
    tbl[7].req = 4'b0100; tbl[7].gid = 2'd2;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", 256'({vld_vec, ack_vec, grant_id, busy, timeout_err}), 256'(0));
    chk("reset_payload", 256'({head_o, addr_o, data_o}), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 256'({vld_vec, busy}), 256'(0));

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Fresh reset, then all four held: 0,1,2,3,0
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    all_four(5, 2'd0);
    // Move the pointer to 2, then all four: 2,3,0,1
    tv = tbl[0];
    tv.req = 4'b0010;
    tv.gid = 2'd1;
    run_txn(tv);
    all_four(4, 2'd2);

    // Reset mid-BUSY with rr_ptr=2; the pending request restarts from 0
    @(negedge clk);
    d_head_in = 16'h5A5A;
    d_addr_in = 32'h0000_3000;
    d_data_in = {4{32'h1234_5678}};
    i_addr_in = 32'hABCD_0040;
    set_valids(4'b0101);
    wait_vld(lat);
    chk("pre_rst_gid", 256'(grant_id), 256'(2));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midbusy_rst_ctl", 256'({vld_vec, ack_vec, grant_id, busy, timeout_err}), 256'(0));
    chk("midbusy_rst_payload", 256'({head_o, addr_o, data_o}), 256'(0));
    @(negedge clk);
    chk("rst_no_ack", 256'({ack_vec, busy}), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("regrant_gid", 256'(grant_id), 256'(0));
    chk("regrant_vld", 256'(vld_vec), 256'(4'b0001));
    chk("regrant_payload", 256'({head_o, addr_o, data_o}),
        256'({16'h5A5A, 32'h0000_3000, {4{32'h1234_5678}}}));
    finish_txn(2'd0, 32'h0000_3000);

    // No done for 110 cycles: the access is never abandoned
    @(negedge clk);
    infifos_addr_in = 32'h0F1F_0000;
    set_valids(4'b1000);
    wait_vld(lat);
    chk("stuck_gid", 256'(grant_id), 256'(3));
    hi = 0;
    te = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (vld_vec == 4'b1000) hi++;
      if (timeout_err) te++;
    end
    chk("stuck_vld_cycles", 256'(hi), 256'(110));
    chk("stuck_no_timeout", 256'(te), 256'(0));
    finish_txn(2'd3, 32'h0F1F_0000);

    // done while IDLE is ignored
    mem_access_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_done_ignored", 256'({vld_vec, ack_vec, busy}), 256'(0));
    end
    mem_access_done = 1'b0;

    // Payload and winner stay frozen while inputs change during BUSY
    @(negedge clk);
    d_head_in = 16'h0B0B;
    d_addr_in = 32'h0000_0100;
    d_data_in = {4{32'hCAFE_F00D}};
    set_valids(4'b0001);
    wait_vld(lat);
    chk("stab_addr_first", 256'(addr_o), 256'(32'h100));
    d_head_in = 16'hFFFF;
    d_addr_in = 32'h0000_0200;
    d_data_in = '0;
    set_valids(4'b0100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stab_addr", 256'(addr_o), 256'(32'h100));
      chk("stab_head_data", 256'({head_o, data_o}), 256'({16'h0B0B, {4{32'hCAFE_F00D}}}));
      chk("stab_vld_gid", 256'({vld_vec, grant_id}), 256'({4'b0001, 2'd0}));
    end
    finish_txn(2'd0, 32'h0000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
